// File: rtl/sent_pkg.sv
// Shared SENT receiver definitions: FSM states, interval classes, tick
// limits, CRC seed/table and the two small helpers built on them.
package sent_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_SYNC,
        ST_STATUS,
        ST_DATA,
        ST_CRC,
        ST_POST
    } rx_state_e;

    typedef enum logic [1:0] {
        CLS_ILLEGAL,
        CLS_SYNC,
        CLS_NIBBLE,
        CLS_PAUSE
    } ivl_cls_e;

    localparam int SYNC_MIN  = 55;
    localparam int SYNC_MAX  = 57;
    localparam int NIB_MIN   = 12;
    localparam int NIB_MAX   = 27;
    localparam int PAUSE_MIN = 58;

    localparam logic [3:0] CRC_SEED = 4'b0101;

    // Index 0 sits in the least significant nibble.
    localparam logic [15:0][3:0] CRC_TABLE = {
        4'd5, 4'd8, 4'd2, 4'd15, 4'd11, 4'd6, 4'd12, 4'd1,
        4'd4, 4'd9, 4'd3, 4'd14, 4'd10, 4'd7, 4'd13, 4'd0
    };

    function automatic logic [3:0] crc_step(input logic [3:0] crc, input logic [3:0] nib);
        return nib ^ CRC_TABLE[crc];
    endfunction

    // tmo is the saturation value; intervals at or above it never count as pause.
    function automatic ivl_cls_e classify(input logic [9:0] t, input int tmo);
        int v;
        v = int'(t);
        if (v >= SYNC_MIN && v <= SYNC_MAX) return CLS_SYNC;
        if (v >= NIB_MIN && v <= NIB_MAX)   return CLS_NIBBLE;
        if (v >= PAUSE_MIN && v < tmo)      return CLS_PAUSE;
        return CLS_ILLEGAL;
    endfunction

endpackage

// File: rtl/sent_rx_pulse_timer.sv
// SENT line timing: 2-flop synchronizer, falling-edge detect, tick prescaler
// and saturating tick counter. Reports the rounded fe-to-fe interval and a
// one-cycle timeout pulse when the open interval reaches TMO_TICKS.
module sent_rx_pulse_timer #(
    parameter int CLK_PER_TICK = 4,
    parameter int TMO_TICKS    = 1023
) (
    input  logic       clk_tx,
    input  logic       reset_tx,
    input  logic       sent_in_i,
    output logic       fe_strobe_o,
    output logic [9:0] interval_o,
    output logic       timeout_o
);
    localparam int PW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_TICK - 1);
    localparam logic [PW-1:0] PRE_HALF = PW'(CLK_PER_TICK / 2);
    localparam logic [9:0]    TMO      = 10'(TMO_TICKS);

    logic          s1_q, s2_q, s3_q;
    logic [PW-1:0] pre_q, pre_d;
    logic [9:0]    tick_q, tick_d;
    logic          tmo_q, tmo_d;
    logic          wrap;

    assign fe_strobe_o = s3_q & ~s2_q;
    assign wrap        = (pre_q == PRE_LAST);
    // Rounding is suppressed once saturated so the result stays at TMO.
    assign interval_o  = tick_q + {9'd0, (pre_q >= PRE_HALF) && (tick_q != TMO)};
    assign timeout_o   = tmo_q;

    // Synchronizer plus edge-history flop; idle line level is high.
    always_ff @(posedge clk_tx or posedge reset_tx) begin
        if (reset_tx) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= sent_in_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Prescaler/tick counter next state; a falling edge restarts both.
    always_comb begin
        pre_d  = wrap ? '0 : pre_q + PW'(1);
        tick_d = tick_q;
        tmo_d  = 1'b0;
        if (wrap && tick_q != TMO) begin
            tick_d = tick_q + 10'd1;
            tmo_d  = (tick_q == TMO - 10'd1);
        end
        if (fe_strobe_o) begin
            pre_d  = '0;
            tick_d = '0;
            tmo_d  = 1'b0;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_tx or posedge reset_tx) begin
        if (reset_tx) begin
            pre_q  <= '0;
            tick_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
            tmo_q  <= tmo_d;
        end
    end

endmodule

// File: rtl/sent_rx_decoder.sv
// SENT receiver decoder: classifies intervals, assembles status + NUM_DATA
// data nibbles + CRC, checks the CRC and strobes frame_valid.
// Optional build macro SENT_RX_PAUSE_EN: accept one pause pulse between
// frames instead of treating it as a framing error.
module sent_rx_decoder
    import sent_pkg::*;
#(
    parameter int CLK_PER_TICK = 4,
    parameter int NUM_DATA     = 6,
    parameter int TMO_TICKS    = 1023
) (
    input  logic        clk_tx,
    input  logic        reset_tx,
    input  logic        enable,
    input  logic        sent_in,
    input  logic        crc_mode,
    output logic        frame_valid,
    output logic [3:0]  status_nibble,
    output logic [23:0] data_out,
    output logic [3:0]  crc_rx,
    output logic        crc_err,
    output logic        frame_err,
    output logic        busy
);
    localparam int DW = 4 * NUM_DATA;

    logic       fe, timeout;
    logic [9:0] interval;
    ivl_cls_e   cls;
    logic [3:0] nib, crc_fin;
    logic       in_frame;

    rx_state_e   state_q, state_d;
    logic [3:0]  stat_w_q, stat_w_d;
    logic [DW-1:0] data_w_q, data_w_d;
    logic [3:0]  crc_q, crc_d;
    logic [2:0]  idx_q, idx_d;
    logic [3:0]  status_q, status_d, crc_rx_q, crc_rx_d;
    logic [DW-1:0] data_o_q, data_o_d;
    logic        fv_q, fv_d, crc_err_q, crc_err_d, ferr_q, ferr_d;
`ifdef SENT_RX_PAUSE_EN
    logic        pause_q, pause_d;
`endif

    sent_rx_pulse_timer #(
        .CLK_PER_TICK (CLK_PER_TICK),
        .TMO_TICKS    (TMO_TICKS)
    ) u_timer (
        .clk_tx      (clk_tx),
        .reset_tx    (reset_tx),
        .sent_in_i   (sent_in),
        .fe_strobe_o (fe),
        .interval_o  (interval),
        .timeout_o   (timeout)
    );

    assign cls      = classify(interval, TMO_TICKS);
    // Nibble intervals are 12..27, so the low 4 bits minus 12 wrap to the value.
    assign nib      = interval[3:0] - 4'd12;
    assign crc_fin  = crc_mode ? crc_step(crc_q, 4'h0) : crc_q;
    assign in_frame = (state_q == ST_STATUS) || (state_q == ST_DATA) || (state_q == ST_CRC);

    assign frame_valid   = fv_q;
    assign status_nibble = status_q;
    assign data_out      = 24'(data_o_q);
    assign crc_rx        = crc_rx_q;
    assign crc_err       = crc_err_q;
    assign frame_err     = ferr_q;
    assign busy          = in_frame;

    // Frame FSM: advances on falling edges; timeout and enable abort.
    always_comb begin
        state_d   = state_q;
        stat_w_d  = stat_w_q;
        data_w_d  = data_w_q;
        crc_d     = crc_q;
        idx_d     = idx_q;
        status_d  = status_q;
        data_o_d  = data_o_q;
        crc_rx_d  = crc_rx_q;
        crc_err_d = crc_err_q;
        fv_d      = 1'b0;
        ferr_d    = 1'b0;
`ifdef SENT_RX_PAUSE_EN
        pause_d   = pause_q;
`endif
        if (!enable) begin
            state_d = ST_WAIT_SYNC;
        end else if (fe) begin
            case (state_q)
                ST_WAIT_SYNC: if (cls == CLS_SYNC) state_d = ST_STATUS;
                ST_STATUS: begin
                    if (cls == CLS_NIBBLE) begin
                        stat_w_d = nib;
                        crc_d    = CRC_SEED;
                        idx_d    = '0;
                        state_d  = ST_DATA;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_SYNC;
                    end
                end
                ST_DATA: begin
                    if (cls == CLS_NIBBLE) begin
                        data_w_d = (data_w_q << 4) | DW'(nib);
                        crc_d    = crc_step(crc_q, nib);
                        if (idx_q == 3'(NUM_DATA - 1)) state_d = ST_CRC;
                        else                            idx_d   = idx_q + 3'd1;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_SYNC;
                    end
                end
                ST_CRC: begin
                    if (cls == CLS_NIBBLE) begin
                        crc_rx_d  = nib;
                        crc_err_d = (nib != crc_fin);
                        status_d  = stat_w_q;
                        data_o_d  = data_w_q;
                        fv_d      = 1'b1;
                        state_d   = ST_POST;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_SYNC;
                    end
                end
                ST_POST: begin
                    if (cls == CLS_SYNC) state_d = ST_STATUS;
`ifdef SENT_RX_PAUSE_EN
                    else if (cls == CLS_PAUSE && !pause_q) pause_d = 1'b1;
`endif
                    else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_SYNC;
                    end
                end
                default: state_d = ST_WAIT_SYNC;
            endcase
        end else if (timeout) begin
            ferr_d  = in_frame;
            state_d = ST_WAIT_SYNC;
        end
`ifdef SENT_RX_PAUSE_EN
        // Only one pause is tolerated per inter-frame gap.
        if (state_d != ST_POST) pause_d = 1'b0;
`endif
    end

    // Decoder state and output registers.
    always_ff @(posedge clk_tx or posedge reset_tx) begin
        if (reset_tx) begin
            state_q   <= ST_WAIT_SYNC;
            stat_w_q  <= '0;
            data_w_q  <= '0;
            crc_q     <= '0;
            idx_q     <= '0;
            status_q  <= '0;
            data_o_q  <= '0;
            crc_rx_q  <= '0;
            crc_err_q <= 1'b0;
            fv_q      <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef SENT_RX_PAUSE_EN
            pause_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            stat_w_q  <= stat_w_d;
            data_w_q  <= data_w_d;
            crc_q     <= crc_d;
            idx_q     <= idx_d;
            status_q  <= status_d;
            data_o_q  <= data_o_d;
            crc_rx_q  <= crc_rx_d;
            crc_err_q <= crc_err_d;
            fv_q      <= fv_d;
            ferr_q    <= ferr_d;
`ifdef SENT_RX_PAUSE_EN
            pause_q   <= pause_d;
`endif
        end
    end

endmodule

// File: tb/tb_sent_rx_decoder.sv
// Self-checking bench for sent_rx_decoder (CLK_PER_TICK=4, NUM_DATA=6).
// Frames are streamed back to back; a scoreboard queue holds the expected
// frames and a monitor checks every frame_valid and counts frame_err pulses.
`timescale 1ns/1ps
module tb_sent_rx_decoder;
    logic        clk_tx = 1'b0;
    logic        reset_tx = 1'b1;
    logic        enable = 1'b1;
    logic        sent_in = 1'b1;
    logic        crc_mode = 1'b0;
    logic        frame_valid, crc_err, frame_err, busy;
    logic [3:0]  status_nibble, crc_rx;
    logic [23:0] data_out;

    sent_rx_decoder #(.CLK_PER_TICK(4), .NUM_DATA(6), .TMO_TICKS(1023)) dut (
        .clk_tx        (clk_tx),
        .reset_tx      (reset_tx),
        .enable        (enable),
        .sent_in       (sent_in),
        .crc_mode      (crc_mode),
        .frame_valid   (frame_valid),
        .status_nibble (status_nibble),
        .data_out      (data_out),
        .crc_rx        (crc_rx),
        .crc_err       (crc_err),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    always #5 clk_tx = ~clk_tx;

    int n_cmp = 0, n_bad = 0, err_cnt = 0, exp_err = 0;

    typedef struct { logic [3:0] st; logic [23:0] data; logic [3:0] crc; logic err; } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic mode; int sync_t; logic [3:0] st; logic [23:0] d; logic [3:0] crc; logic err;
    } vec_t;
    vec_t vecs[7];

    logic [3:0] tbl [16] = '{4'd0, 4'd13, 4'd7, 4'd10, 4'd14, 4'd3, 4'd9, 4'd4,
                             4'd1, 4'd12, 4'd6, 4'd11, 4'd15, 4'd2, 4'd8, 4'd5};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference CRC over the data nibbles, first nibble first.
    function automatic logic [3:0] crc_ref(input logic [23:0] d, input logic mode);
        logic [3:0] c;
        c = 4'h5;
        for (int k = 0; k < 6; k++) c = d[4*(5-k) +: 4] ^ tbl[c];
        if (mode) c = tbl[c];
        return c;
    endfunction

    // Scoreboard monitor.
    always @(negedge clk_tx) begin
        exp_t e;
        if (frame_err) err_cnt++;
        if (frame_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_frame_valid: got frame_valid=1 with no frame expected");
            end else begin
                e = exp_q.pop_front();
                check("status_nibble", status_nibble, e.st);
                check("data_out", data_out, e.data);
                check("crc_rx", crc_rx, e.crc);
                check("crc_err", crc_err, e.err);
            end
        end
    end

    // One interval of t ticks, starting with a falling edge.
    task automatic send_iv(input int t);
        sent_in = 1'b0;
        repeat (16) @(negedge clk_tx);
        sent_in = 1'b1;
        repeat (4*t - 16) @(negedge clk_tx);
    endtask

    // Full frame; bad_t > 0 replaces data nibble 1 with a raw interval.
    task automatic send_frame(input logic mode, input int sync_t, input logic [3:0] st,
                              input logic [23:0] d, input logic [3:0] crc,
                              input int bad_t, input logic exp_e);
        if (bad_t > 0) exp_err++;
        else exp_q.push_back('{st, d, crc, exp_e});
        sent_in = 1'b0;
        // Mode switches only after the previous CRC nibble has closed.
        repeat (16) @(negedge clk_tx);
        crc_mode = mode;
        sent_in = 1'b1;
        repeat (4*sync_t - 16) @(negedge clk_tx);
        send_iv(int'(st) + 12);
        for (int k = 0; k < 6; k++)
            send_iv((k == 1 && bad_t > 0) ? bad_t : int'(d[4*(5-k) +: 4]) + 12);
        send_iv(int'(crc) + 12);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic m;
        logic [3:0] st, cr, good;
        logic [23:0] d;

        vecs[0] = '{1'b0, 56, 4'h0, 24'h000000, 4'hF, 1'b0};
        vecs[1] = '{1'b1, 55, 4'h0, 24'h000000, 4'h5, 1'b0};
        vecs[2] = '{1'b1, 57, 4'h0, 24'h000000, 4'hF, 1'b1};
        vecs[3] = '{1'b0, 56, 4'h3, 24'h123456, 4'hD, 1'b0};
        vecs[4] = '{1'b1, 56, 4'h3, 24'h123456, 4'h2, 1'b0};
        vecs[5] = '{1'b0, 55, 4'h3, 24'h123456, 4'hC, 1'b1};
        vecs[6] = '{1'b0, 57, 4'hF, 24'hFFFFFF, 4'h3, 1'b0};

        // Reset state.
        repeat (3) @(negedge clk_tx);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_status", status_nibble, 0);
        check("rst_data", data_out, 0);
        check("rst_crc_rx", crc_rx, 0);
        check("rst_crc_err", crc_err, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_busy", busy, 0);
        reset_tx = 1'b0;
        repeat (5) @(negedge clk_tx);

        // Vector table, frames back to back.
        foreach (vecs[i])
            send_frame(vecs[i].mode, vecs[i].sync_t, vecs[i].st, vecs[i].d, vecs[i].crc, 0, vecs[i].err);

        // Illegal 30-tick nibble in DATA, then a clean frame.
        send_frame(1'b0, 56, 4'h9, 24'hA5C3E1, 4'h0, 30, 1'b0);
        send_frame(1'b0, 56, 4'h2, 24'h0F1E2D, crc_ref(24'h0F1E2D, 1'b0), 0, 1'b0);

        // 200-tick pause between frames. Without pause support the pause is
        // a framing error; the sync that follows still starts a new frame.
        send_frame(1'b0, 56, 4'h4, 24'h112233, crc_ref(24'h112233, 1'b0), 0, 1'b0);
        send_iv(200);
`ifndef SENT_RX_PAUSE_EN
        exp_err++;
`endif
        send_frame(1'b0, 56, 4'h5, 24'h445566, crc_ref(24'h445566, 1'b0), 0, 1'b0);
        // Two pauses: one framing error in either build.
        send_iv(200);
        send_iv(200);
        exp_err++;
        send_frame(1'b0, 56, 4'h6, 24'h778899, crc_ref(24'h778899, 1'b0), 0, 1'b0);

        // Line held high mid-frame: timeout at tick 1023.
        send_iv(56);
        send_iv(3 + 12);
        send_iv(7 + 12);
        sent_in = 1'b0;
        repeat (16) @(negedge clk_tx);
        sent_in = 1'b1;
        check("busy_in_data", busy, 1);
        c = 16;
        while (!frame_err && c < 5000) begin
            @(negedge clk_tx);
            c++;
        end
        check("timeout_frame_err", frame_err, 1);
        check("timeout_latency_ok", (c >= 4092 && c <= 4104), 1);
        exp_err++;
        @(negedge clk_tx);
        c++;
        check("timeout_busy", busy, 0);
        repeat (4*1100 - c) @(negedge clk_tx);
        send_frame(1'b0, 56, 4'hA, 24'hBCDEF0, crc_ref(24'hBCDEF0, 1'b0), 0, 1'b0);

        // enable dropped mid-frame: silent drop.
        send_iv(56);
        send_iv(1 + 12);
        send_iv(4 + 12);
        sent_in = 1'b0;
        repeat (8) @(negedge clk_tx);
        enable = 1'b0;
        @(negedge clk_tx);
        check("enable_low_busy", busy, 0);
        repeat (7) @(negedge clk_tx);
        enable = 1'b1;
        sent_in = 1'b1;
        repeat (4*17 - 16) @(negedge clk_tx);
        for (int k = 0; k < 5; k++) send_iv(12 + k);
        send_frame(1'b0, 56, 4'h3, 24'h123456, 4'hD, 0, 1'b0);

        // Reset during DATA.
        send_iv(56);
        send_iv(2 + 12);
        send_iv(9 + 12);
        sent_in = 1'b0;
        repeat (8) @(negedge clk_tx);
        #2 reset_tx = 1'b1;
        #1;
        check("mid_rst_status", status_nibble, 0);
        check("mid_rst_data", data_out, 0);
        check("mid_rst_crc_rx", crc_rx, 0);
        check("mid_rst_crc_err", crc_err, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_frame_valid", frame_valid, 0);
        check("mid_rst_frame_err", frame_err, 0);
        repeat (4) @(negedge clk_tx);
        reset_tx = 1'b0;
        sent_in = 1'b1;
        repeat (400) @(negedge clk_tx);
        check("pending_after_reset", exp_q.size(), 0);
        check("frame_err_count_mid", err_cnt, exp_err);
        send_frame(1'b0, 56, 4'h7, 24'h0A0B0C, crc_ref(24'h0A0B0C, 1'b0), 0, 1'b0);

        // Random frames against the reference CRC.
        for (int i = 0; i < 16; i++) begin
            m    = 1'($urandom_range(0, 1));
            st   = 4'($urandom);
            d    = 24'($urandom);
            good = crc_ref(d, m);
            cr   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : good;
            send_frame(m, $urandom_range(55, 57), st, d, cr, 0, cr != good);
        end

        // Closing edge, then idle past the timeout (not busy: no error).
        sent_in = 1'b0;
        repeat (16) @(negedge clk_tx);
        sent_in = 1'b1;
        repeat (4*1040) @(negedge clk_tx);
        check("pending_at_end", exp_q.size(), 0);
        check("frame_err_count", err_cnt, exp_err);
        check("idle_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
